// File: rtl/milestone1_pkg.sv
// rtl/milestone1_pkg.sv - shared types and constants for the milestone-1 colour-space converter
package milestone1_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MY,
        S_MRV,
        S_MGU,
        S_MGV,
        S_MBU,
        S_OUT
    } csc_state_t;

    // Q16 coefficients of the BT.601 YUV-to-RGB matrix
    localparam logic [31:0] COEF_Y  = 32'd76284;
    localparam logic [31:0] COEF_RV = 32'd104595;
    localparam logic [31:0] COEF_GU = 32'd25624;
    localparam logic [31:0] COEF_GV = 32'd53281;
    localparam logic [31:0] COEF_BU = 32'd132251;

    localparam logic [7:0] Y_OFFSET = 8'd16;
    localparam logic [7:0] C_OFFSET = 8'd128;

endpackage

// File: rtl/milestone1_clip8.sv
// rtl/milestone1_clip8.sv - signed Q16 accumulator to unsigned 8-bit pixel clip
module milestone1_clip8 (
    input  logic [31:0] acc_i,
    output logic [7:0]  pix_o
);

    // Fractional bits only matter for rounding, which this path truncates away
    logic unused_frac;
    assign unused_frac = ^acc_i[15:0];

    always_comb begin
        pix_o = acc_i[23:16];
        if (acc_i[31]) begin
            pix_o = 8'd0;
        end else if (|acc_i[30:24]) begin
            pix_o = 8'hFF;
        end
    end

endmodule

// File: rtl/milestone1_csc_sequencer.sv
// rtl/milestone1_csc_sequencer.sv - YUV-to-RGB sequencer driving one shared external multiplier lane
module milestone1_csc_sequencer
    import milestone1_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_y,
    input  logic [7:0]  in_u,
    input  logic [7:0]  in_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [31:0] mult_result
);

    csc_state_t  state_q, state_d;
    logic [31:0] ys_q, ys_d;
    logic [31:0] us_q, us_d;
    logic [31:0] vs_q, vs_d;
    logic [31:0] acc_y_q, acc_y_d;
    logic [31:0] acc_r_q, acc_r_d;
    logic [31:0] acc_g_q, acc_g_d;
    logic [31:0] acc_b_q, acc_b_d;
    logic [7:0]  out_r_q, out_r_d;
    logic [7:0]  out_g_q, out_g_d;
    logic [7:0]  out_b_q, out_b_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] op1, op2;
    logic [31:0] acc_b_sum;
    logic [7:0]  clip_r, clip_g, clip_b;

    // Blue is clipped in the same cycle its product arrives, so it bypasses acc_b_q
    assign acc_b_sum = acc_y_q + mult_result;

    milestone1_clip8 u_clip_r (.acc_i(acc_r_q),   .pix_o(clip_r));
    milestone1_clip8 u_clip_g (.acc_i(acc_g_q),   .pix_o(clip_g));
    milestone1_clip8 u_clip_b (.acc_i(acc_b_sum), .pix_o(clip_b));

    always_comb begin
        state_d     = state_q;
        ys_d        = ys_q;
        us_d        = us_q;
        vs_d        = vs_q;
        acc_y_d     = acc_y_q;
        acc_r_d     = acc_r_q;
        acc_g_d     = acc_g_q;
        acc_b_d     = acc_b_q;
        out_r_d     = out_r_q;
        out_g_d     = out_g_q;
        out_b_d     = out_b_q;
        out_valid_d = out_valid_q;
        op1         = 32'd0;
        op2         = 32'd0;
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ys_d    = {24'd0, in_y} - {24'd0, Y_OFFSET};
                    us_d    = {24'd0, in_u} - {24'd0, C_OFFSET};
                    vs_d    = {24'd0, in_v} - {24'd0, C_OFFSET};
                    state_d = S_MY;
                end
            end
            S_MY: begin
                op1     = ys_q;
                op2     = COEF_Y;
                acc_y_d = mult_result;
                state_d = S_MRV;
            end
            S_MRV: begin
                op1     = vs_q;
                op2     = COEF_RV;
                acc_r_d = acc_y_q + mult_result;
                state_d = S_MGU;
            end
            S_MGU: begin
                op1     = us_q;
                op2     = COEF_GU;
                acc_g_d = acc_y_q - mult_result;
                state_d = S_MGV;
            end
            S_MGV: begin
                op1     = vs_q;
                op2     = COEF_GV;
                acc_g_d = acc_g_q - mult_result;
                state_d = S_MBU;
            end
            S_MBU: begin
                op1         = us_q;
                op2         = COEF_BU;
                acc_b_d     = acc_b_sum;
                out_r_d     = clip_r;
                out_g_d     = clip_g;
                out_b_d     = clip_b;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The multiplier is shared, so it sees zero operands whenever reset is asserted
    assign mult_op1 = Resetn ? op1 : 32'd0;
    assign mult_op2 = Resetn ? op2 : 32'd0;

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            ys_q        <= 32'd0;
            us_q        <= 32'd0;
            vs_q        <= 32'd0;
            acc_y_q     <= 32'd0;
            acc_r_q     <= 32'd0;
            acc_g_q     <= 32'd0;
            acc_b_q     <= 32'd0;
            out_r_q     <= 8'd0;
            out_g_q     <= 8'd0;
            out_b_q     <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ys_q        <= ys_d;
            us_q        <= us_d;
            vs_q        <= vs_d;
            acc_y_q     <= acc_y_d;
            acc_r_q     <= acc_r_d;
            acc_g_q     <= acc_g_d;
            acc_b_q     <= acc_b_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_milestone1_csc_sequencer.sv
// tb/tb_milestone1_csc_sequencer.sv - self-checking bench for the colour-space-conversion sequencer
module tb_milestone1_csc_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_y, in_u, in_v;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_r, out_g, out_b;
    logic [31:0] mult_op1, mult_op2;
    logic [31:0] mult_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    // External shared multiplier lane: low 32 bits of the product, same cycle
    assign mult_result = mult_op1 * mult_op2;

    milestone1_csc_sequencer dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_y        (in_y),
        .in_u        (in_u),
        .in_v        (in_v),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .mult_op1    (mult_op1),
        .mult_op2    (mult_op2),
        .mult_result (mult_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic int clip(input longint a);
        if (a < 0) return 0;
        if (a / 65536 > 255) return 255;
        return int'(a / 65536);
    endfunction

    // Reference: plain BT.601 arithmetic on wide integers
    task automatic model(input int y, input int u, input int v,
                         output int r, output int g, output int b);
        longint ay;
        ay = longint'(y - 16) * 76284;
        r  = clip(ay + longint'(v - 128) * 104595);
        g  = clip(ay - longint'(u - 128) * 25624 - longint'(v - 128) * 53281);
        b  = clip(ay + longint'(u - 128) * 132251);
    endtask

    task automatic scramble_inputs();
        in_valid = 1'($urandom);
        in_y     = 8'($urandom);
        in_u     = 8'($urandom);
        in_v     = 8'($urandom);
    endtask

    task automatic run_pixel(input int y, input int u, input int v, input int stall);
        int waited;
        int er, eg, eb;
        int exp_op1 [5];
        int exp_op2 [5];
        waited = 0;
        model(y, u, v, er, eg, eb);
        exp_op1 = '{y - 16, v - 128, u - 128, v - 128, u - 128};
        exp_op2 = '{76284, 104595, 25624, 53281, 132251};
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_y     = 8'(y);
        in_u     = 8'(u);
        in_v     = 8'(v);
        in_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("busy_out_valid", 32'(out_valid), 32'd0);
            check("busy_in_ready", 32'(in_ready), 32'd0);
            check("busy_op1", mult_op1, 32'(exp_op1[k]));
            check("busy_op2", mult_op2, 32'(exp_op2[k]));
            scramble_inputs();
            tick();
        end
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("pix_r", 32'(out_r), 32'(er));
        check("pix_g", 32'(out_g), 32'(eg));
        check("pix_b", 32'(out_b), 32'(eb));
        check("out_op1_zero", mult_op1, 32'd0);
        for (int s = 0; s < stall; s++) begin
            scramble_inputs();
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_r", 32'(out_r), 32'(er));
            check("stall_g", 32'(out_g), 32'(eg));
            check("stall_b", 32'(out_b), 32'(eb));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("idle_op2_zero", mult_op2, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_y      = 8'd200;
        in_u      = 8'd10;
        in_v      = 8'd250;
        #1;
        check("reset_op1_comb", mult_op1, 32'd0);
        check("reset_op2_comb", mult_op2, 32'd0);
        tick();
        tick();
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_r", 32'(out_r), 32'd0);
        check("reset_out_g", 32'(out_g), 32'd0);
        check("reset_out_b", 32'(out_b), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_op1", mult_op1, 32'd0);
        in_valid = 1'b0;
        Resetn   = 1'b1;
        tick();

        run_pixel(16, 128, 128, 0);
        run_pixel(235, 128, 128, 0);
        run_pixel(255, 128, 128, 1);
        run_pixel(16, 0, 255, 0);
        run_pixel(0, 255, 0, 2);
        run_pixel(200, 60, 180, 5);

        for (int i = 0; i < 20; i++) begin
            run_pixel(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        // Abort a pixel in S_MGU and confirm it never emerges
        in_y     = 8'd100;
        in_u     = 8'd50;
        in_v     = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("abort_mgu_op1", mult_op1, 32'(50 - 128));
        check("abort_mgu_op2", mult_op2, 32'd25624);
        Resetn = 1'b0;
        #1;
        check("abort_reset_op1", mult_op1, 32'd0);
        check("abort_reset_op2", mult_op2, 32'd0);
        tick();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        Resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("abort_no_pixel", 32'(out_valid), 32'd0);
        end
        run_pixel(235, 128, 128, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
